// File: rtl/mem_stage_if.sv
// Wishbone classic master/slave bundle used by the MEM stage.
interface mem_stage_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  wb_cyc_o;
  logic                  wb_stb_o;
  logic                  wb_we_o;
  logic [ADDR_WIDTH-1:0] wb_adr_o;
  logic [DATA_WIDTH-1:0] wb_dat_o;
  logic [3:0]            wb_sel_o;
  logic [DATA_WIDTH-1:0] wb_dat_i;
  logic                  wb_ack_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/mem_stage.sv
// Pipeline MEM stage: issues one Wishbone cycle per load/store, stalls upstream until it
// completes, and drives the MEM/WB register.
module mem_stage #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic                  MemSize,
  input  logic                  MemtoReg,
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] ALU_result,
  input  logic [DATA_WIDTH-1:0] rs2_data,
  input  logic [4:0]            rd_addr,
  mem_stage_if.master           wb,
  output logic                  mem_stall,
  output logic                  RegWrite_out,
  output logic                  MemtoReg_out,
  output logic [4:0]            rd_addr_out,
  output logic [DATA_WIDTH-1:0] wb_data_out
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e                state_q, state_d;
  logic                  regwrite_q, memtoreg_q, is_read_q, size_q;
  logic [1:0]            off_q;
  logic [4:0]            rd_q;
  logic [ADDR_WIDTH-1:0] alu_q;
  logic [DATA_WIDTH-1:0] load_q;
  logic [7:0]            lane;
  logic [DATA_WIDTH-1:0] load_fmt;
  logic                  req;

  assign req = MemRead | MemWrite;

  always_comb begin
    state_d   = state_q;
    mem_stall = 1'b0;
    case (state_q)
      StIdle: begin
        if (req) begin
          mem_stall = 1'b1;
          state_d   = StBusy;
        end
      end
      StBusy: begin
        mem_stall = 1'b1;
        if (wb.wb_ack_i) state_d = StBusy == StBusy ? StDone : StBusy;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (reset) begin
      mem_stall = 1'b0;
      state_d   = StIdle;
    end
  end

  always_comb begin
    lane = 8'h00;
    unique case (off_q)
      2'd0: lane = wb.wb_dat_i[7:0];
      2'd1: lane = wb.wb_dat_i[15:8];
      2'd2: lane = wb.wb_dat_i[23:16];
      2'd3: lane = wb.wb_dat_i[31:24];
    endcase
    load_fmt = size_q ? wb.wb_dat_i : {{(DATA_WIDTH-8){lane[7]}}, lane};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      wb.wb_cyc_o  <= 1'b0;
      wb.wb_stb_o  <= 1'b0;
      wb.wb_we_o   <= 1'b0;
      wb.wb_adr_o  <= '0;
      wb.wb_dat_o  <= '0;
      wb.wb_sel_o  <= 4'h0;
      RegWrite_out <= 1'b0;
      MemtoReg_out <= 1'b0;
      rd_addr_out  <= 5'd0;
      wb_data_out  <= '0;
      regwrite_q   <= 1'b0;
      memtoreg_q   <= 1'b0;
      is_read_q    <= 1'b0;
      size_q       <= 1'b0;
      off_q        <= 2'd0;
      rd_q         <= 5'd0;
      alu_q        <= '0;
      load_q       <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        StIdle: begin
          if (req) begin
            wb.wb_cyc_o  <= 1'b1;
            wb.wb_stb_o  <= 1'b1;
            wb.wb_we_o   <= MemWrite;
            wb.wb_adr_o  <= {ALU_result[ADDR_WIDTH-1:2], 2'b00};
            wb.wb_dat_o  <= MemSize ? rs2_data : {4{rs2_data[7:0]}};
            wb.wb_sel_o  <= MemSize ? 4'hF : (4'b0001 << ALU_result[1:0]);
            // A simultaneous read+write is a store; the result is the ALU value.
            is_read_q    <= MemRead & ~MemWrite;
            size_q       <= MemSize;
            off_q        <= ALU_result[1:0];
            regwrite_q   <= RegWrite;
            memtoreg_q   <= MemtoReg;
            rd_q         <= rd_addr;
            alu_q        <= ALU_result;
            RegWrite_out <= 1'b0;
          end else begin
            RegWrite_out <= RegWrite;
            MemtoReg_out <= MemtoReg;
            rd_addr_out  <= rd_addr;
            wb_data_out  <= ALU_result;
          end
        end
        StBusy: begin
          RegWrite_out <= 1'b0;
          if (wb.wb_ack_i) begin
            wb.wb_cyc_o <= 1'b0;
            wb.wb_stb_o <= 1'b0;
            wb.wb_we_o  <= 1'b0;
            load_q      <= load_fmt;
          end
        end
        StDone: begin
          RegWrite_out <= regwrite_q;
          MemtoReg_out <= memtoreg_q;
          rd_addr_out  <= rd_q;
          wb_data_out  <= is_read_q ? load_q : alu_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, hand sequences, and random
// instructions checked against a transaction-level model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite, MemSize, MemtoReg, RegWrite;
  logic [31:0] ALU_result, rs2_data;
  logic [4:0]  rd_addr;
  logic        mem_stall, RegWrite_out, MemtoReg_out;
  logic [4:0]  rd_addr_out;
  logic [31:0] wb_data_out;

  int total = 0;
  int bad   = 0;
  int low_run  = 0;
  int last_gap = 0;

  mem_stage_if bus ();

  mem_stage dut (
    .clk          (clk),
    .reset        (reset),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .MemSize      (MemSize),
    .MemtoReg     (MemtoReg),
    .RegWrite     (RegWrite),
    .ALU_result   (ALU_result),
    .rs2_data     (rs2_data),
    .rd_addr      (rd_addr),
    .wb           (bus),
    .mem_stall    (mem_stall),
    .RegWrite_out (RegWrite_out),
    .MemtoReg_out (MemtoReg_out),
    .rd_addr_out  (rd_addr_out),
    .wb_data_out  (wb_data_out)
  );

  always #5 clk = ~clk;

  // Length of the most recent run of cycles with cyc low.
  always @(negedge clk) begin
    if (bus.wb_cyc_o === 1'b1) begin
      if (low_run > 0) last_gap = low_run;
      low_run = 0;
    end else begin
      low_run = low_run + 1;
    end
  end

  typedef struct {
    logic        rd, wr, sz, m2r, rw;
    logic [31:0] alu, rs2;
    logic [4:0]  rdaddr;
    logic [31:0] rdata;
    int          delay;
    logic [31:0] exp_adr;
    logic [3:0]  exp_sel;
    logic [31:0] exp_dat;
    logic        exp_we;
    logic [31:0] exp_wb;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Transaction-level expectation from the access rules.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    int   lane = int'(v.alu % 4);
    int   b = int'((v.rdata >> (8 * lane)) & 32'hFF);
    if (b >= 128) b = b - 256;
    r.exp_adr = v.alu - (v.alu % 4);
    r.exp_sel = v.sz ? 4'hF : 4'(1 << lane);
    r.exp_dat = v.sz ? v.rs2 : (v.rs2 & 32'hFF) * 32'h01010101;
    r.exp_we  = v.wr;
    if (v.rd && !v.wr) r.exp_wb = v.sz ? v.rdata : 32'(b);
    else               r.exp_wb = v.alu;
    return r;
  endfunction

  task automatic run_instr(input vec_t v);
    int stalls = 0;
    MemRead = v.rd; MemWrite = v.wr; MemSize = v.sz; MemtoReg = v.m2r; RegWrite = v.rw;
    ALU_result = v.alu; rs2_data = v.rs2; rd_addr = v.rdaddr;
    bus.wb_ack_i = 1'($urandom_range(0, 1));
    bus.wb_dat_i = $urandom;
    #1;
    if (!(v.rd || v.wr)) begin
      chk("alu_stall", {31'd0, mem_stall}, 32'd0);
      tick();
      bus.wb_ack_i = 1'b0;
      chk("alu_regwrite", {31'd0, RegWrite_out}, {31'd0, v.rw});
      chk("alu_memtoreg", {31'd0, MemtoReg_out}, {31'd0, v.m2r});
      chk("alu_rd", {27'd0, rd_addr_out}, {27'd0, v.rdaddr});
      chk("alu_data", wb_data_out, v.exp_wb);
    end else begin
      if (mem_stall === 1'b1) stalls++;
      tick();
      for (int i = 0; i < v.delay; i++) begin
        bus.wb_ack_i = (i == v.delay - 1);
        bus.wb_dat_i = (i == v.delay - 1) ? v.rdata : $urandom;
        #1;
        if (mem_stall === 1'b1) stalls++;
        chk("busy_cyc", {31'd0, bus.wb_cyc_o}, 32'd1);
        chk("busy_stb", {31'd0, bus.wb_stb_o}, 32'd1);
        chk("busy_we", {31'd0, bus.wb_we_o}, {31'd0, v.exp_we});
        chk("busy_adr", bus.wb_adr_o, v.exp_adr);
        chk("busy_sel", {28'd0, bus.wb_sel_o}, {28'd0, v.exp_sel});
        chk("busy_dat", bus.wb_dat_o, v.exp_dat);
        chk("busy_regwrite", {31'd0, RegWrite_out}, 32'd0);
        tick();
      end
      bus.wb_ack_i = 1'($urandom_range(0, 1));
      bus.wb_dat_i = $urandom;
      #1;
      if (mem_stall === 1'b1) stalls++;
      chk("stall_cycles", stalls, v.delay + 1);
      chk("done_cyc", {31'd0, bus.wb_cyc_o}, 32'd0);
      chk("done_we", {31'd0, bus.wb_we_o}, 32'd0);
      chk("done_regwrite", {31'd0, RegWrite_out}, 32'd0);
      tick();
      bus.wb_ack_i = 1'b0;
      chk("mem_regwrite", {31'd0, RegWrite_out}, {31'd0, v.rw});
      chk("mem_memtoreg", {31'd0, MemtoReg_out}, {31'd0, v.m2r});
      chk("mem_rd", {27'd0, rd_addr_out}, {27'd0, v.rdaddr});
      chk("mem_data", wb_data_out, v.exp_wb);
    end
  endtask

  vec_t tbl[7];
  vec_t v;

  initial begin
    // rd wr sz m2r rw alu rs2 rdaddr rdata delay | adr sel dat we wb
    tbl[0] = '{0, 0, 1, 0, 1, 32'h0000_1234, 32'h0, 5'd5, 32'h0, 0,
               32'h0, 4'h0, 32'h0, 0, 32'h0000_1234};
    tbl[1] = '{1, 0, 1, 1, 1, 32'h8000_0104, 32'h0, 5'd7, 32'hDEAD_BEEF, 3,
               32'h8000_0104, 4'hF, 32'h0, 0, 32'hDEAD_BEEF};
    tbl[2] = '{1, 0, 0, 1, 1, 32'h8000_0103, 32'h0, 5'd8, 32'h80FF_FFFF, 1,
               32'h8000_0100, 4'b1000, 32'h0, 0, 32'hFFFF_FF80};
    tbl[3] = '{0, 1, 0, 0, 0, 32'h8000_0002, 32'h0000_00AB, 5'd0, 32'h0, 2,
               32'h8000_0000, 4'b0100, 32'hABAB_ABAB, 1, 32'h8000_0002};
    tbl[4] = '{1, 0, 1, 1, 1, 32'h0000_0013, 32'h0, 5'd9, 32'h1122_3344, 1,
               32'h0000_0010, 4'hF, 32'h0, 0, 32'h1122_3344};
    tbl[5] = '{1, 1, 1, 0, 1, 32'h0000_0040, 32'hCAFE_F00D, 5'd3, 32'h5555_5555, 2,
               32'h0000_0040, 4'hF, 32'hCAFE_F00D, 1, 32'h0000_0040};
    tbl[6] = '{1, 0, 0, 1, 1, 32'h0000_0021, 32'h0, 5'd10, 32'h0000_7F00, 1,
               32'h0000_0020, 4'b0010, 32'h0, 0, 32'h0000_007F};

    reset = 1'b1;
    MemRead = 1'b0; MemWrite = 1'b0; MemSize = 1'b0; MemtoReg = 1'b0; RegWrite = 1'b0;
    ALU_result = '0; rs2_data = '0; rd_addr = '0;
    bus.wb_ack_i = 1'b0; bus.wb_dat_i = '0;
    tick();
    tick();
    chk("rst_cyc", {31'd0, bus.wb_cyc_o}, 32'd0);
    chk("rst_stb", {31'd0, bus.wb_stb_o}, 32'd0);
    chk("rst_we", {31'd0, bus.wb_we_o}, 32'd0);
    chk("rst_adr", bus.wb_adr_o, 32'd0);
    chk("rst_dat", bus.wb_dat_o, 32'd0);
    chk("rst_sel", {28'd0, bus.wb_sel_o}, 32'd0);
    chk("rst_regwrite", {31'd0, RegWrite_out}, 32'd0);
    chk("rst_memtoreg", {31'd0, MemtoReg_out}, 32'd0);
    chk("rst_rd", {27'd0, rd_addr_out}, 32'd0);
    chk("rst_data", wb_data_out, 32'd0);
    MemRead = 1'b1;
    #1;
    chk("rst_stall", {31'd0, mem_stall}, 32'd0);
    MemRead = 1'b0;
    reset = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) run_instr(tbl[i]);

    // Back-to-back store then load: two separate bus cycles with a 2-cycle gap.
    v = '{0, 1, 1, 0, 0, 32'h0000_0200, 32'h1357_9BDF, 5'd0, 32'h0, 1,
          32'h0, 4'h0, 32'h0, 0, 32'h0};
    run_instr(model(v));
    v = '{1, 0, 1, 1, 1, 32'h0000_0200, 32'h0, 5'd12, 32'h1357_9BDF, 1,
          32'h0, 4'h0, 32'h0, 0, 32'h0};
    run_instr(model(v));
    chk("b2b_gap", last_gap, 2);

    // Reset in the middle of a bus cycle; a later ack must be ignored.
    MemRead = 1'b1; MemWrite = 1'b0; MemSize = 1'b1; RegWrite = 1'b1; MemtoReg = 1'b1;
    ALU_result = 32'h0000_0400; rd_addr = 5'd4;
    #1;
    tick();
    chk("rb_cyc_before", {31'd0, bus.wb_cyc_o}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rb_stall_in_reset", {31'd0, mem_stall}, 32'd0);
    tick();
    chk("rb_cyc", {31'd0, bus.wb_cyc_o}, 32'd0);
    chk("rb_stb", {31'd0, bus.wb_stb_o}, 32'd0);
    chk("rb_data", wb_data_out, 32'd0);
    reset = 1'b0;
    MemRead = 1'b0; RegWrite = 1'b0; MemtoReg = 1'b0; ALU_result = '0; rd_addr = '0;
    bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'hFFFF_FFFF;
    #1;
    chk("rb_stall_after", {31'd0, mem_stall}, 32'd0);
    tick();
    tick();
    bus.wb_ack_i = 1'b0;
    chk("rb_cyc_after_ack", {31'd0, bus.wb_cyc_o}, 32'd0);
    chk("rb_regwrite", {31'd0, RegWrite_out}, 32'd0);
    chk("rb_data_after", wb_data_out, 32'd0);

    for (int n = 0; n < 60; n++) begin
      int kind = int'($urandom_range(0, 3));
      v.rd     = (kind == 1) || (kind == 3);
      v.wr     = (kind == 2) || (kind == 3);
      v.sz     = 1'($urandom_range(0, 1));
      v.m2r    = 1'($urandom_range(0, 1));
      v.rw     = 1'($urandom_range(0, 1));
      v.alu    = $urandom;
      v.rs2    = $urandom;
      v.rdaddr = 5'($urandom);
      v.rdata  = $urandom;
      v.delay  = int'($urandom_range(1, 4));
      run_instr(model(v));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width (only 32 is supported).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width (only 32 is supported).
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports MemRead, MemWrite, MemSize, MemtoReg, RegWrite  in  1 each  control bits from the EX/MEM register; MemSize 1 = 32-bit access, 0 = 8-bit access.
REQ-006 SHALL have ports ALU_result  in  32  (address or ALU value); rs2_data  in  32  (store data); rd_addr  in  5  (destination register).
REQ-007 SHALL have Wishbone master ports wb_cyc_o, wb_stb_o, wb_we_o  out  1; wb_adr_o  out  32; wb_dat_o  out  32; wb_sel_o  out  4; wb_dat_i  in  32; wb_ack_i  in  1.
REQ-008 SHALL have port mem_stall  out  1  combinational; high means hold all upstream pipeline registers.
REQ-009 SHALL have registered MEM/WB outputs RegWrite_out  out  1, MemtoReg_out  out  1, rd_addr_out  out  5, wb_data_out  out  32.

Function
REQ-010 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-011 IDLE, no request (MemRead=0 and MemWrite=0): mem_stall=0; next edge loads RegWrite_out/MemtoReg_out/rd_addr_out from inputs and wb_data_out <= ALU_result (1-cycle latency).
REQ-012 IDLE with MemRead or MemWrite: mem_stall=1 combinationally; next edge latches address, data, sel, we, rd_addr, RegWrite, MemtoReg, MemSize, byte offset; asserts wb_cyc_o=wb_stb_o=1; enters BUSY.
REQ-013 BUSY: mem_stall=1; cyc/stb/we/adr/dat/sel held stable until wb_ack_i=1; wait length unbounded.
REQ-014 BUSY with wb_ack_i=1: same edge deasserts cyc/stb, captures formatted load data into internal buffer, enters DONE.
REQ-015 DONE (exactly one cycle): mem_stall=0; next edge writes latched RegWrite/MemtoReg/rd_addr to outputs, wb_data_out <= load data if read else latched ALU_result; returns to IDLE.
REQ-016 On every edge where mem_stall=1, RegWrite_out SHALL be forced to 0 (bubble to WB; no double write).
REQ-017 MemWrite=1 and MemRead=1 together: treated as write; wb_data_out takes ALU_result.
REQ-018 Word access: wb_adr_o={ALU_result[31:2],2'b00}, wb_sel_o=4'hF, wb_dat_o=rs2_data; misaligned low bits ignored.
REQ-019 Byte access: wb_adr_o={ALU_result[31:2],2'b00}, wb_sel_o=4'b0001<<ALU_result[1:0], wb_dat_o={4{rs2_data[7:0]}}.
REQ-020 Byte load result: lane wb_dat_i[8*off+7:8*off], sign-extended to 32 bits; word load: wb_dat_i unchanged.
REQ-021 wb_ack_i SHALL be ignored in IDLE and DONE.
REQ-022 wb_we_o=1 only for write cycles; 0 whenever wb_cyc_o=0.

Reset
REQ-023 reset high at an edge: state <= IDLE; wb_cyc_o, wb_stb_o, wb_we_o <= 0; wb_adr_o, wb_dat_o, wb_data_out <= 0; wb_sel_o <= 4'h0; RegWrite_out, MemtoReg_out <= 0; rd_addr_out <= 0.
REQ-024 reset during BUSY SHALL abandon the transaction (cyc/stb low after that edge); a later ack SHALL be ignored.
REQ-025 mem_stall SHALL be 0 while reset is asserted.

Verification
REQ-026 ALU op: RegWrite=1, rd=5, ALU_result=0x1234, no mem -> next cycle RegWrite_out=1, rd_addr_out=5, wb_data_out=0x1234, mem_stall never high.
REQ-027 LW addr 0x80000104, ack after 3 BUSY cycles, wb_dat_i=0xDEADBEEF -> sel=F, adr=0x80000104, mem_stall high 4 cycles, RegWrite_out=0 during stall, then wb_data_out=0xDEADBEEF, RegWrite_out=1.
REQ-028 LB addr 0x80000103, wb_dat_i=0x80FFFFFF, ack immediately -> sel=4'b1000, wb_data_out=0xFFFFFF80.
REQ-029 SB addr 0x80000002, rs2_data=0x000000AB -> we=1, sel=4'b0100, dat=0xABABABAB; RegWrite_out stays 0.
REQ-030 Reset asserted in BUSY, then ack pulses -> cyc/stb low after reset edge, state IDLE, no output update, mem_stall=0.
REQ-031 Back-to-back SW then LW, each acked after 1 cycle -> two distinct bus cycles, cyc low for at least DONE+IDLE cycles between them, both complete in order.
